// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock-enable divider.
package clk_div_pkg;
  localparam int DIV_W = 8;
  typedef logic [DIV_W-1:0] div_t;
  localparam div_t DIV_DISABLED = '0;

  // Widened by one bit so the maximum divisor does not overflow.
  function automatic logic [DIV_W:0] half_high(input div_t d);
    return ({1'b0, d} + (DIV_W+1)'(1)) >> 1;
  endfunction
endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active divisor and a shadow divisor that is
// applied at a period boundary, while disabled, or on sync.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             sync,
  output logic             ce,
  output logic             div_clk,
  output logic             pending
);
  typedef logic [DIV_W-1:0] cdiv_t;
  localparam cdiv_t DEF = cdiv_t'(DEFAULT_DIV);
  localparam cdiv_t DIS = cdiv_t'(DIV_DISABLED);

  cdiv_t      cnt_q, cnt_d;
  cdiv_t      active_q, active_d;
  cdiv_t      shadow_q, shadow_d;
  logic       pending_q, pending_d;
  logic       ce_q, ce_d;
  logic       clk_q, clk_d;
  logic       enabled, period_end, apply;
  logic [DIV_W:0] half;

  always_comb begin
    enabled    = (active_q != DIS);
    period_end = enabled && (cnt_q == active_q - cdiv_t'(1));
    half       = ({1'b0, active_q} + (DIV_W+1)'(1)) >> 1;

    ce_d  = period_end;
    clk_d = enabled && ({1'b0, cnt_q} < half);

    // Sync uses the shadow as it stood before this cycle's write.
    apply    = pending_q && (sync || period_end || !enabled);
    active_d = apply ? shadow_q : active_q;

    cnt_d = cnt_q + cdiv_t'(1);
    if (sync || apply || period_end || !enabled) cnt_d = '0;

    shadow_d  = load ? load_div : shadow_q;
    pending_d = load || (pending_q && !apply);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      active_q  <= DEF;
      shadow_q  <= DEF;
      pending_q <= 1'b0;
      ce_q      <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ce_q      <= ce_d;
      clk_q     <= clk_d;
    end
  end

  assign ce      = ce_q;
  assign div_clk = clk_q;
  assign pending = pending_q;
endmodule

// File: rtl/clock_enable_divider.sv
// Multi-channel runtime-programmable clock divider producing enable strobes
// and divided square waves; config writes are decoded to one channel.
module clock_enable_divider
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cfg_valid,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [DIV_W-1:0]  i_cfg_div,
  output logic              o_cfg_ready,
  input  logic              i_sync,
  output logic [NUM_CH-1:0] o_pending,
  output logic [NUM_CH-1:0] o_ce,
  output logic [NUM_CH-1:0] o_clk
);
  logic [NUM_CH-1:0] load;

  assign o_cfg_ready = !reset;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Channel numbers past NUM_CH match no instance, so such writes drop.
    assign load[c] = i_cfg_valid && o_cfg_ready && (i_cfg_ch == CH_W'(c));

    clk_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .load     (load[c]),
      .load_div (i_cfg_div),
      .sync     (i_sync),
      .ce       (o_ce[c]),
      .div_clk  (o_clk[c]),
      .pending  (o_pending[c])
    );
  end
endmodule
